iir_deemph: RTL and testbench

IIR_DEEMPH -- requirements
Module: iir_deemph

---
 rtl/iir_deemph_if.sv | 21 ++
 rtl/iir_deemph.sv | 110 +++++++++++
 tb/tb_iir_deemph.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_deemph_if.sv
// FIFO-side handshake bundle for the de-emphasis IIR: upstream FWFT read port and downstream write port.
interface iir_deemph_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic [DATA_WIDTH-1:0] in_dout;
   logic                  in_empty;
   logic                  in_rd_en;
   logic [DATA_WIDTH-1:0] out_din;
   logic                  out_wr_en;
   logic                  out_full;

   modport slave (
      input  in_dout, in_empty, out_full,
      output in_rd_en, out_din, out_wr_en
   );

   modport master (
      output in_dout, in_empty, out_full,
      input  in_rd_en, out_din, out_wr_en
   );
endinterface

// File: rtl/iir_deemph.sv
// Sequential one-tap-per-cycle IIR de-emphasis filter in Q10 fixed point.
// Optional build macro IIR_DEEMPH_CLAMP_EN saturates each result to signed 16-bit.
//
// state   | meaning
// S_READ  | wait for an input sample, pop it and shift histories
// S_RUN   | accumulate one feed-forward + feedback tap per cycle
// S_WRITE | push the result downstream, hold it while the FIFO is full
module iir_deemph #(
   parameter int                    TAPS       = 2,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [TAPS-1:0][31:0] X_COEFF    = {32'h000000B2, 32'h000000B2},
   parameter logic [TAPS-1:0][31:0] Y_COEFF    = {32'h00000294, 32'h00000000}
) (
   input logic         clock,
   input logic         reset,
   iir_deemph_if.slave bus
);
   localparam int            KW     = $clog2(TAPS);
   localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

   typedef enum logic [1:0] {S_READ, S_RUN, S_WRITE} state_t;

   state_t                        r_state;
   logic signed [DATA_WIDTH-1:0]  r_x_hist [TAPS];
   logic signed [31:0]            r_y_hist [TAPS];
   logic signed [31:0]            r_acc;
   logic [KW-1:0]                 r_k;

   logic                          w_rd;
   logic                          w_wr;
   logic signed [31:0]            w_tap;
   logic signed [31:0]            w_result;

   // Full 64-bit product, arithmetic >>10, keep low 32 bits.
   function automatic logic signed [31:0] mul(input logic [31:0] p, input logic signed [31:0] q);
      logic signed [63:0] prod;
      prod = 64'(signed'(p)) * 64'(q);
      return prod[41:10];
   endfunction

   always_comb begin
      w_tap = mul(X_COEFF[r_k], 32'(r_x_hist[r_k])) + mul(Y_COEFF[r_k], r_y_hist[r_k]);
   end

`ifdef IIR_DEEMPH_CLAMP_EN
   always_comb begin
      if (r_acc > 32'sd32767)
         w_result = 32'sd32767;
      else if (r_acc < -32'sd32768)
         w_result = -32'sd32768;
      else
         w_result = r_acc;
   end
`else
   always_comb begin
      w_result = r_acc;
   end
`endif

   // Handshakes are combinational so a read/write lands in the same cycle the FIFO allows it.
   assign w_rd          = (r_state == S_READ)  && !bus.in_empty && !reset;
   assign w_wr          = (r_state == S_WRITE) && !bus.out_full && !reset;
   assign bus.in_rd_en  = w_rd;
   assign bus.out_wr_en = w_wr;
   assign bus.out_din   = w_wr ? DATA_WIDTH'(w_result) : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_READ;
         r_acc   <= '0;
         r_k     <= '0;
         for (int i = 0; i < TAPS; i++) begin
            r_x_hist[i] <= '0;
            r_y_hist[i] <= '0;
         end
      end else begin
         case (r_state)
            S_READ: begin
               if (w_rd) begin
                  r_x_hist[0] <= bus.in_dout;
                  r_y_hist[0] <= '0;
                  for (int i = 1; i < TAPS; i++) begin
                     r_x_hist[i] <= r_x_hist[i-1];
                     r_y_hist[i] <= r_y_hist[i-1];
                  end
                  r_acc   <= '0;
                  r_k     <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= r_acc + w_tap;
               if (r_k == K_LAST) begin
                  r_k     <= '0;
                  r_state <= S_WRITE;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            S_WRITE: begin
               if (w_wr) begin
                  r_y_hist[0] <= w_result;
                  r_state     <= S_READ;
               end
            end
            default: r_state <= S_READ;
         endcase
      end
   end
endmodule

// File: tb/tb_iir_deemph.sv
// Self-checking bench for iir_deemph: directed spec scenarios plus randomized traffic against a difference-equation model.
module tb_iir_deemph;
   localparam int TAPS = 2;
   localparam int B_REF [TAPS] = '{178, 178};
   localparam int A_REF [TAPS] = '{0, 660};

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   iir_deemph_if #(.DATA_WIDTH(32)) bus ();

   iir_deemph dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   int xs[$];
   int ys[$];
   int exp_q[$];
   int src_q[$];
   int out_log[$];
   int rd_cyc_q[$];
   int rd_log[$];

   int   cyc       = 0;
   int   n_reads   = 0;
   int   n_writes  = 0;
   int   last_lat  = 0;
   logic last_rd   = 1'b0;
   logic last_wr   = 1'b0;
   logic [31:0] last_din = '0;
   logic force_empty = 1'b0;
   logic force_full  = 1'b0;
   logic rnd_stall   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
      end
   endtask

   function automatic int mul_ref(input int p, input int q);
      longint pr;
      pr = longint'(p) * longint'(q);
      return int'(pr >>> 10);
   endfunction

   // y[n] = sum b[i]x[n-i] + sum_{i>=1} a[i]y[n-i], history zero before reset.
   task automatic model_push(input int x);
      int y;
      xs.push_front(x);
      if (xs.size() > TAPS) void'(xs.pop_back());
      y = 0;
      for (int i = 0; i < TAPS; i++) begin
         if (i < xs.size()) y += mul_ref(B_REF[i], xs[i]);
         if (i >= 1 && (i - 1) < ys.size()) y += mul_ref(A_REF[i], ys[i-1]);
      end
`ifdef IIR_DEEMPH_CLAMP_EN
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
`endif
      ys.push_front(y);
      if (ys.size() > TAPS) void'(ys.pop_back());
      exp_q.push_back(y);
   endtask

   task automatic tick();
      int x;
      if (rnd_stall) begin
         force_empty = ($urandom_range(0, 3) == 0);
         force_full  = ($urandom_range(0, 3) == 0);
      end
      bus.in_empty = (src_q.size() == 0) || force_empty;
      bus.in_dout  = (src_q.size() != 0) ? src_q[0] : 32'hDEAD_BEEF;
      bus.out_full = force_full;
      @(negedge clock);
      last_rd  = bus.in_rd_en;
      last_wr  = bus.out_wr_en;
      last_din = bus.out_din;
      check("rd_wr_exclusive", {31'd0, last_rd & last_wr}, 32'd0);
      if (!last_wr) check("din_idle_zero", last_din, 32'd0);
      if (reset) begin
         check("rst_rd_en", {31'd0, last_rd}, 32'd0);
         check("rst_wr_en", {31'd0, last_wr}, 32'd0);
      end
      if (last_rd) begin
         x = src_q.pop_front();
         model_push(x);
         rd_cyc_q.push_back(cyc);
         rd_log.push_back(cyc);
         n_reads++;
      end
      if (last_wr) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", 32'd1, 32'd0);
         end else begin
            check("data", last_din, exp_q.pop_front());
            last_lat = cyc - rd_cyc_q.pop_front();
         end
         out_log.push_back(int'(last_din));
         n_writes++;
      end
      if (reset) begin
         xs.delete(); ys.delete(); exp_q.delete(); rd_cyc_q.delete(); rd_log.delete();
      end
      @(posedge clock);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      src_q.delete();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      out_log.delete();
   endtask

   task automatic wait_writes(input int n, input int budget);
      int start;
      start = n_writes;
      for (int i = 0; i < budget && n_writes < start + n; i++) tick();
      if (n_writes < start + n) check("timeout_writes", n_writes - start, n);
   endtask

   task automatic wait_read(input int budget);
      int start;
      start = n_reads;
      for (int i = 0; i < budget && n_reads == start; i++) tick();
      if (n_reads == start) check("timeout_read", 32'd0, 32'd1);
   endtask

   initial begin
      int wr0;
      int v;
      bus.in_empty = 1'b1;
      bus.in_dout  = '0;
      bus.out_full = 1'b0;

      // Reset with data available: no pop, no push.
      reset = 1'b1;
      src_q.push_back(1024);
      tick();
      check("reset_rd_en", {31'd0, last_rd}, 32'd0);
      check("reset_wr_en", {31'd0, last_wr}, 32'd0);
      check("reset_din", last_din, 32'd0);
      tick();
      reset = 1'b0;
      src_q.delete();
      repeat (3) tick();
      check("post_reset_idle_wr", {31'd0, last_wr}, 32'd0);

      // Impulse response, latency and throughput.
      do_reset();
      src_q.push_back(1024); src_q.push_back(0); src_q.push_back(0);
      wait_writes(1, 50);
      check("latency", last_lat, TAPS + 1);
      wait_writes(2, 50);
      if (out_log.size() == 3) begin
         check("impulse0", out_log[0], 178);
         check("impulse1", out_log[1], 292);
         check("impulse2", out_log[2], 188);
      end else check("impulse_count", out_log.size(), 3);
      if (rd_log.size() >= 2) check("throughput", rd_log[1] - rd_log[0], TAPS + 2);

      // Sign.
      do_reset();
      src_q.push_back(-1024);
      wait_writes(1, 50);
      if (out_log.size() == 1) check("sign", out_log[0], -178);

      // Clamp.
      do_reset();
      src_q.push_back(32'h0010_0000);
`ifdef IIR_DEEMPH_CLAMP_EN
      v = 32767;
`else
      v = 182272;
`endif
      wait_writes(1, 50);
      if (out_log.size() == 1) check("clamp", out_log[0], v);

      // Backpressure: held result, no reads while stalled.
      do_reset();
      force_full = 1'b1;
      src_q.push_back(1024); src_q.push_back(0);
      wait_read(20);
      repeat (TAPS) tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_wr_en", {31'd0, last_wr}, 32'd0);
         check("bp_rd_en", {31'd0, last_rd}, 32'd0);
         check("bp_din", last_din, 32'd0);
      end
      force_full = 1'b0;
      tick();
      check("bp_release_wr", {31'd0, last_wr}, 32'd1);
      check("bp_release_din", last_din, 32'd178);
      wait_writes(1, 50);
      if (out_log.size() == 2) check("bp_next", out_log[1], 292);

      // Starvation.
      do_reset();
      force_empty = 1'b1;
      src_q.push_back(512);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("starve_rd_en", {31'd0, last_rd}, 32'd0);
         check("starve_wr_en", {31'd0, last_wr}, 32'd0);
      end
      force_empty = 1'b0;
      tick();
      check("starve_release_rd", {31'd0, last_rd}, 32'd1);
      wait_writes(1, 50);
      if (out_log.size() == 1) check("starve_data", out_log[0], 89);

      // Reset at RUN tap 1.
      do_reset();
      src_q.push_back(20000);
      wait_read(20);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wr0 = n_writes;
      repeat (6) tick();
      check("midrun_no_write", n_writes - wr0, 0);
      out_log.delete();
      src_q.push_back(1024);
      wait_writes(1, 50);
      if (out_log.size() == 1) check("midrun_fresh", out_log[0], 178);

      // Randomized traffic with random stalls on both sides.
      do_reset();
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 2))
            0: v = int'($urandom_range(0, 4095)) - 2048;
            1: v = int'($urandom);
            default: v = 0;
         endcase
         src_q.push_back(v);
      end
      rnd_stall = 1'b1;
      wait_writes(200, 200 * (TAPS + 2) * 6);
      rnd_stall = 1'b0;
      force_empty = 1'b0;
      force_full  = 1'b0;
      repeat (10) tick();
      check("rand_all_consumed", src_q.size(), 0);
      check("rand_none_pending", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
